// File: rtl/ram_controller.sv
// Word-organised single-port RAM that services one-cycle read/write request
// pulses and answers each one with a one-cycle ack after a fixed latency.
// A low-priority load port preloads memory while the controller is idle.
//
// state   | meaning
// IDLE    | waiting for a request; the load port is accepted here
// RD_WAIT | read captured, latency counter running
// WR_WAIT | write captured, latency counter running
// ACK     | one-cycle ack; read data is valid on ramIn
module ram_controller #(
  parameter int          DEPTH_LOG2    = 10,
  parameter int          READ_LATENCY  = 2,
  parameter int          WRITE_LATENCY = 1,
  parameter logic [31:0] OOR_DATA      = 32'hdeadbeef
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        readReq,
  input  logic        writeReq,
  input  logic [31:0] ramAddress,
  input  logic [31:0] ramOut,
  output logic [31:0] ramIn,
  output logic        readAck,
  output logic        writeAck,
  input  logic        loadEn,
  input  logic [31:0] loadAddress,
  input  logic [31:0] loadData,
  output logic        busy,
  output logic        err
);

  localparam int          DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [3:0]  RD_CNT = 4'(READ_LATENCY - 1);
  localparam logic [3:0]  WR_CNT = 4'(WRITE_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_WR_WAIT, S_ACK} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [3:0]              r_cnt;
  logic [DEPTH_LOG2-1:0]   r_idx;
  logic                    r_oor;
  logic [31:0]             r_data;
  logic                    r_is_read;
  logic                    r_err;
  logic [31:0]             r_ram_in;
  logic [31:0]             r_mem [DEPTH];

  logic                    w_cap_rd;
  logic                    w_cap_wr;
  logic                    w_load;
  logic                    w_err_set;
  logic                    w_waiting;
  logic                    w_done;
  logic                    w_req_oor;
  logic                    w_req_mis;
  logic                    w_ld_oor;
  logic                    w_ld_mis;
  logic [DEPTH_LOG2-1:0]   w_req_idx;
  logic [DEPTH_LOG2-1:0]   w_ld_idx;

  assign w_req_oor = |ramAddress[31:DEPTH_LOG2+2];
  assign w_req_mis = |ramAddress[1:0];
  assign w_req_idx = ramAddress[DEPTH_LOG2+1:2];
  assign w_ld_oor  = |loadAddress[31:DEPTH_LOG2+2];
  assign w_ld_mis  = |loadAddress[1:0];
  assign w_ld_idx  = loadAddress[DEPTH_LOG2+1:2];

  // Counter is loaded with LATENCY-1 and the wait state is always visited,
  // so the ack rises on edge N+LATENCY for a request captured on edge N.
  assign w_waiting = (r_state == S_RD_WAIT) || (r_state == S_WR_WAIT);
  assign w_done    = w_waiting && (r_cnt == 4'd0);

  // Next-state decode, request/load arbitration and error detection.
  always_comb begin
    w_next    = r_state;
    w_cap_rd  = 1'b0;
    w_cap_wr  = 1'b0;
    w_load    = 1'b0;
    w_err_set = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (writeReq) begin
          w_cap_wr = 1'b1;
          w_next   = S_WR_WAIT;
          if (readReq || loadEn || w_req_oor || w_req_mis) w_err_set = 1'b1;
        end else if (readReq) begin
          w_cap_rd = 1'b1;
          w_next   = S_RD_WAIT;
          if (loadEn || w_req_oor || w_req_mis) w_err_set = 1'b1;
        end else if (loadEn) begin
          if (w_ld_oor) w_err_set = 1'b1;
          else          w_load    = 1'b1;
          if (w_ld_mis) w_err_set = 1'b1;
        end
      end
      S_RD_WAIT, S_WR_WAIT: begin
        if (readReq || writeReq || loadEn) w_err_set = 1'b1;
        if (r_cnt == 4'd0) w_next = S_ACK;
      end
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Control registers: state, latency counter, captured request, read data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_idx     <= '0;
      r_oor     <= 1'b0;
      r_data    <= 32'd0;
      r_is_read <= 1'b0;
      r_err     <= 1'b0;
      r_ram_in  <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_err_set) r_err <= 1'b1;
      if (w_cap_wr || w_cap_rd) begin
        r_idx     <= w_req_idx;
        r_oor     <= w_req_oor;
        r_data    <= ramOut;
        r_is_read <= w_cap_rd;
        r_cnt     <= w_cap_rd ? RD_CNT : WR_CNT;
      end else if (w_waiting && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_done && r_state == S_RD_WAIT)
        r_ram_in <= r_oor ? OOR_DATA : r_mem[r_idx];
    end
  end

  // Memory array is never cleared; writes commit on the edge entering ACK.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (w_load)
        r_mem[w_ld_idx] <= loadData;
      else if (w_done && r_state == S_WR_WAIT && !r_oor)
        r_mem[r_idx] <= r_data;
    end
  end

  assign ramIn    = r_ram_in;
  assign readAck  = (r_state == S_ACK) && r_is_read;
  assign writeAck = (r_state == S_ACK) && !r_is_read;
  assign busy     = (r_state != S_IDLE);
  assign err      = r_err;

endmodule
